exec_mem_stage: RTL and testbench

Parametrised second pipeline stage of the NanoQuarter core: executes ALU, branch and jump operations and performs data-memory loads/stores through an APB master with wait-state support. Accepts one instruction per cycle from stage 1 via a valid/ready handshake, stalls upstream while a memory transfer is outstanding, and presents registered writeback and next-PC results to the register file and fetch logic.

---
 rtl/exec_mem_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_exec_mem_stage.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_stage.sv
// exec_mem_stage: NanoQuarter stage 2, ALU/branch execute plus APB data access.
// Define APB_TIMEOUT_EN to bound ACCESS waits by TIMEOUT cycles and raise err.
module exec_mem_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int PC_W   = 32
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op_in,
  input  logic [2:0]        funct_in,
  input  logic [3:0]        shamt_in,
  input  logic [DATA_W-1:0] reg1data_in,
  input  logic [DATA_W-1:0] reg2data_in,
  input  logic [7:0]        idata_in,
  input  logic [7:0]        jtarget_in,
  input  logic [4:0]        boffset_in,
  input  logic [ADDR_W-1:0] memaddr_in,
  input  logic [2:0]        wdst_in,
  input  logic [PC_W-1:0]   PC_in,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [2:0]        wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic              pc_load,
  output logic [PC_W-1:0]   PC_out,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] data;
    logic              pc_load;
    logic [PC_W-1:0]   pc;
  } res_t;

  state_t state;
  logic   accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  logic op_alu, op_imm, op_mem, op_ctl;

  assign op_alu = (op_in == 2'b00);
  assign op_imm = (op_in == 2'b01);
  assign op_mem = (op_in == 2'b10);
  assign op_ctl = (op_in == 2'b11);

  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_z;
  logic [DATA_W-1:0] slt;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   jmp_off;
  logic [PC_W-1:0]   br_off;

  assign imm_s   = {{(DATA_W-8){idata_in[7]}}, idata_in};
  assign imm_z   = {{(DATA_W-8){1'b0}}, idata_in};
  assign slt     = {{(DATA_W-1){1'b0}},
                    $signed(reg1data_in) < $signed(reg2data_in)};
  assign pc_inc  = PC_in + PC_W'(1);
  assign jmp_off = {{(PC_W-8){jtarget_in[7]}}, jtarget_in};
  assign br_off  = {{(PC_W-5){boffset_in[4]}}, boffset_in};

  res_t res;
  logic is_load;
  logic is_store;

  always_comb begin
    res      = '0;
    res.pc   = pc_inc;
    is_load  = 1'b0;
    is_store = 1'b0;
    unique case (1'b1)
      op_alu: begin
        res.we = 1'b1;
        unique case (funct_in)
          3'd0: res.data = reg1data_in + reg2data_in;
          3'd1: res.data = reg1data_in - reg2data_in;
          3'd2: res.data = reg1data_in & reg2data_in;
          3'd3: res.data = reg1data_in | reg2data_in;
          3'd4: res.data = reg1data_in ^ reg2data_in;
          3'd5: res.data = reg1data_in << shamt_in;
          3'd6: res.data = reg1data_in >> shamt_in;
          default: res.data = slt;
        endcase
      end
      op_imm: begin
        if (funct_in == 3'd0) begin
          res.we   = 1'b1;
          res.data = reg1data_in + imm_s;
        end else if (funct_in == 3'd1) begin
          res.we   = 1'b1;
          res.data = imm_z;
        end
      end
      op_mem: begin
        is_load  = (funct_in == 3'd0);
        is_store = (funct_in == 3'd1);
      end
      op_ctl: begin
        unique case (funct_in)
          3'd0: begin
            res.pc_load = 1'b1;
            res.pc      = PC_in + jmp_off;
          end
          3'd1: begin
            if (reg1data_in != reg2data_in) begin
              res.pc_load = 1'b1;
              res.pc      = pc_inc + br_off;
            end
          end
          3'd2: begin
            res.pc_load = 1'b1;
            res.pc      = PC_W'(reg1data_in);
          end
          default: res.pc_load = 1'b0;
        endcase
      end
      default: res.pc_load = 1'b0;
    endcase
  end

  // Memory ops park their writeback fields here until the APB transfer ends.
  logic            mem_load;
  logic [2:0]      mem_dst;
  logic [PC_W-1:0] mem_pc;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_dst   <= '0;
      wb_data  <= '0;
      pc_load  <= 1'b0;
      PC_out   <= '0;
      mem_load <= 1'b0;
      mem_dst  <= '0;
      mem_pc   <= '0;
`ifdef APB_TIMEOUT_EN
      err      <= 1'b0;
      cnt      <= '0;
`endif
    end else begin
      wb_valid <= 1'b0;
      pc_load  <= 1'b0;
`ifdef APB_TIMEOUT_EN
      err      <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (is_load | is_store) begin
              state    <= SETUP;
              psel     <= 1'b1;
              penable  <= 1'b0;
              paddr    <= memaddr_in;
              pwrite   <= is_store;
              pwdata   <= reg2data_in;
              mem_load <= is_load;
              mem_dst  <= wdst_in;
              mem_pc   <= pc_inc;
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= res.we;
              wb_dst   <= wdst_in;
              wb_data  <= res.data;
              pc_load  <= res.pc_load;
              PC_out   <= res.pc;
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            state    <= IDLE;
            psel     <= 1'b0;
            penable  <= 1'b0;
            wb_valid <= 1'b1;
            wb_we    <= mem_load;
            wb_dst   <= mem_dst;
            wb_data  <= mem_load ? prdata : '0;
            PC_out   <= mem_pc;
          end
`ifdef APB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state    <= IDLE;
            psel     <= 1'b0;
            penable  <= 1'b0;
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
            wb_dst   <= mem_dst;
            wb_data  <= '0;
            PC_out   <= mem_pc;
            err      <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_mem_stage.sv
// tb_exec_mem_stage: randomized scoreboard bench with an APB memory slave.
// Define APB_TIMEOUT_EN to also exercise the ACCESS timeout path.
module tb_exec_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op_in;
  logic [2:0]  funct_in;
  logic [3:0]  shamt_in;
  logic [15:0] reg1data_in;
  logic [15:0] reg2data_in;
  logic [7:0]  idata_in;
  logic [7:0]  jtarget_in;
  logic [4:0]  boffset_in;
  logic [5:0]  memaddr_in;
  logic [2:0]  wdst_in;
  logic [31:0] PC_in;
  logic [5:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic        wb_valid;
  logic        wb_we;
  logic [2:0]  wb_dst;
  logic [15:0] wb_data;
  logic        pc_load;
  logic [31:0] PC_out;
  logic        err;

  always #5 clk = ~clk;

  exec_mem_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_in(op_in), .funct_in(funct_in), .shamt_in(shamt_in),
    .reg1data_in(reg1data_in), .reg2data_in(reg2data_in),
    .idata_in(idata_in), .jtarget_in(jtarget_in),
    .boffset_in(boffset_in), .memaddr_in(memaddr_in),
    .wdst_in(wdst_in), .PC_in(PC_in),
    .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dst(wb_dst),
    .wb_data(wb_data), .pc_load(pc_load), .PC_out(PC_out),
    .err(err)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  funct;
    logic [3:0]  shamt;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [7:0]  idata;
    logic [7:0]  jt;
    logic [4:0]  bo;
    logic [5:0]  addr;
    logic [2:0]  dst;
    logic [31:0] pc;
  } instr_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  dst;
    logic [15:0] data;
    logic        pcl;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_mem[64];
  logic [15:0] slave_mem[64];
  int          tests = 0;
  int          fails = 0;
  int          wait_cfg = -1;
  bit          expect_timeout = 1'b0;
  logic [15:0] last_data = '0;
  logic [31:0] last_pc = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on the instruction fields.
  function automatic exp_t model(input instr_t i);
    exp_t   e;
    int     a, b, sa, sb;
    longint p;
    a = int'(i.r1);
    b = int'(i.r2);
    sa = int'($signed(i.r1));
    sb = int'($signed(i.r2));
    p = longint'(i.pc);
    e = '0;
    e.dst = i.dst;
    e.pc = 32'(p + 1);
    case (i.op)
      2'd0: begin
        e.we = 1'b1;
        case (i.funct)
          3'd0: e.data = 16'((a + b) % 65536);
          3'd1: e.data = 16'((a - b + 65536) % 65536);
          3'd2: e.data = i.r1 & i.r2;
          3'd3: e.data = i.r1 | i.r2;
          3'd4: e.data = i.r1 ^ i.r2;
          3'd5: e.data = 16'((longint'(a) * (64'd1 << i.shamt)) % 65536);
          3'd6: e.data = 16'(a / (1 << i.shamt));
          default: e.data = (sa < sb) ? 16'd1 : 16'd0;
        endcase
      end
      2'd1: begin
        if (i.funct == 3'd0) begin
          e.we = 1'b1;
          e.data = 16'((a + int'($signed(i.idata))) & 32'hFFFF);
        end else if (i.funct == 3'd1) begin
          e.we = 1'b1;
          e.data = {8'h00, i.idata};
        end
      end
      2'd2: begin
        if (i.funct == 3'd0) begin
          if (expect_timeout) e.err = 1'b1;
          else begin
            e.we = 1'b1;
            e.data = model_mem[i.addr];
          end
        end else if (i.funct == 3'd1 && !expect_timeout) begin
          model_mem[i.addr] = i.r2;
        end
      end
      default: begin
        if (i.funct == 3'd0) begin
          e.pcl = 1'b1;
          e.pc = 32'(p + longint'($signed(i.jt)));
        end else if (i.funct == 3'd1 && i.r1 != i.r2) begin
          e.pcl = 1'b1;
          e.pc = 32'(p + 1 + longint'($signed(i.bo)));
        end else if (i.funct == 3'd2) begin
          e.pcl = 1'b1;
          e.pc = {16'h0000, i.r1};
        end
      end
    endcase
    return e;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.op = 2'($urandom_range(0, 3));
    i.funct = 3'($urandom_range(0, 7));
    if (i.op != 2'd0 && $urandom_range(0, 3) != 0)
      i.funct = 3'($urandom_range(0, 2));
    i.shamt = 4'($urandom);
    i.r1 = 16'($urandom);
    i.r2 = ($urandom_range(0, 3) == 0) ? i.r1 : 16'($urandom);
    i.idata = 8'($urandom);
    i.jt = 8'($urandom);
    i.bo = 5'($urandom);
    i.addr = 6'($urandom);
    i.dst = 3'($urandom);
    i.pc = $urandom;
    return i;
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input instr_t i);
    int guard = 0;
    in_valid = 1'b1;
    op_in = i.op;
    funct_in = i.funct;
    shamt_in = i.shamt;
    reg1data_in = i.r1;
    reg2data_in = i.r2;
    idata_in = i.idata;
    jtarget_in = i.jt;
    boffset_in = i.bo;
    memaddr_in = i.addr;
    wdst_in = i.dst;
    PC_in = i.pc;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("issue_in_ready", in_ready, 1);
    @(posedge clk);
    exp_q.push_back(model(i));
    #1 in_valid = 1'b0;
  endtask

  task automatic watch_mem(input string tag, input int lat,
                           input logic [5:0] a, input logic w,
                           input logic [15:0] wd);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) begin
        chk({tag, "_in_ready_low"}, in_ready, 0);
        chk({tag, "_psel"}, psel, 1);
        chk({tag, "_penable"}, penable, (k > 1));
        chk({tag, "_paddr"}, paddr, a);
        chk({tag, "_pwrite"}, pwrite, w);
        if (w) chk({tag, "_pwdata"}, pwdata, wd);
      end else begin
        chk({tag, "_wb_valid"}, wb_valid, 1);
        chk({tag, "_in_ready_high"}, in_ready, 1);
        chk({tag, "_psel_done"}, psel, 0);
      end
    end
  endtask

  // APB slave with programmable wait states backed by slave_mem.
  initial begin
    int          wcnt = 0;
    int          target = 0;
    logic        prev_psel = 1'b0;
    logic [5:0]  prev_addr = '0;
    logic        prev_write = 1'b0;
    logic [15:0] prev_wdata = '0;
    pready = 1'b0;
    prdata = '0;
    forever begin
      @(negedge clk);
      if (psel && prev_psel) begin
        chk("apb_paddr_stable", paddr, prev_addr);
        chk("apb_pwrite_stable", pwrite, prev_write);
        chk("apb_pwdata_stable", pwdata, prev_wdata);
      end
      prev_psel = psel;
      prev_addr = paddr;
      prev_write = pwrite;
      prev_wdata = pwdata;
      if (psel && penable) begin
        if (wcnt == 0)
          target = (wait_cfg < 0) ? $urandom_range(0, 3) : wait_cfg;
        if (wcnt >= target) begin
          pready = 1'b1;
          prdata = pwrite ? 16'h0000 : slave_mem[paddr];
          if (pwrite) slave_mem[paddr] = pwdata;
          wcnt = 0;
        end else begin
          pready = 1'b0;
          wcnt++;
        end
      end else begin
        pready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every wb_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (wb_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_wb: wb_valid=1 with nothing outstanding, required 0");
          end else begin
            e = exp_q.pop_front();
            chk("wb_we", wb_we, e.we);
            chk("wb_dst", wb_dst, e.dst);
            if (e.we) chk("wb_data", wb_data, e.data);
            chk("pc_load", pc_load, e.pcl);
            chk("PC_out", PC_out, e.pc);
            chk("err", err, e.err);
          end
        end else begin
          chk("idle_pc_load", pc_load, 0);
          chk("idle_err", err, 0);
          chk("hold_wb_data", wb_data, last_data);
          chk("hold_PC_out", PC_out, last_pc);
        end
        last_data = wb_data;
        last_pc = PC_out;
      end
    end
  end

  initial begin
    instr_t d;
    in_valid = 1'b0;
    op_in = '0;
    funct_in = '0;
    shamt_in = '0;
    reg1data_in = '0;
    reg2data_in = '0;
    idata_in = '0;
    jtarget_in = '0;
    boffset_in = '0;
    memaddr_in = '0;
    wdst_in = '0;
    PC_in = '0;
    for (int m = 0; m < 64; m++) begin
      model_mem[m] = 16'($urandom);
      slave_mem[m] = model_mem[m];
    end

    #1 rst = 1'b0;
    #1;
    chk("reset_apb_wb", {psel, penable, pwrite, paddr, pwdata,
                         wb_valid, wb_we, wb_dst}, 0);
    chk("reset_data_flags", {wb_data, pc_load, err}, 0);
    chk("reset_PC_out", PC_out, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    @(negedge clk);
    d = '0;
    d.r1 = 16'h7FFF;
    d.r2 = 16'h0001;
    d.dst = 3'd1;
    d.pc = 32'd100;
    issue(d);
    @(negedge clk);
    chk("b2b_add_valid", wb_valid, 1);
    chk("add_overflow_data", wb_data, 16'h8000);
    d.funct = 3'd7;
    d.r1 = 16'h8000;
    issue(d);
    @(negedge clk);
    chk("b2b_slt_valid", wb_valid, 1);
    chk("slt_signed_data", wb_data, 16'h0001);

    d = '0;
    d.op = 2'd3;
    d.funct = 3'd1;
    d.r1 = 16'd3;
    d.r2 = 16'd4;
    d.pc = 32'd10;
    d.bo = 5'b11110;
    issue(d);
    @(negedge clk);
    chk("bne_PC_out", PC_out, 32'd9);
    chk("bne_pc_load", pc_load, 1);
    d.funct = 3'd2;
    d.r1 = 16'h0040;
    issue(d);
    @(negedge clk);
    chk("jr_PC_out", PC_out, 32'h40);
    chk("jr_pc_load", pc_load, 1);

    model_mem[5] = 16'hBEEF;
    slave_mem[5] = 16'hBEEF;
    wait_cfg = 2;
    d = '0;
    d.op = 2'd2;
    d.addr = 6'h05;
    d.dst = 3'd3;
    d.pc = 32'd20;
    issue(d);
    watch_mem("load", 5, 6'h05, 1'b0, 16'h0000);
    chk("load_wb_data", wb_data, 16'hBEEF);
    chk("load_wb_we", wb_we, 1);

    wait_cfg = 0;
    d.funct = 3'd1;
    d.addr = 6'h3F;
    d.r2 = 16'h1234;
    issue(d);
    watch_mem("store", 3, 6'h3F, 1'b1, 16'h1234);
    chk("store_wb_we", wb_we, 0);
    chk("store_slave_mem", slave_mem[63], 16'h1234);

`ifdef APB_TIMEOUT_EN
    wait_cfg = 1000;
    expect_timeout = 1'b1;
    d.funct = 3'd0;
    d.addr = 6'h11;
    issue(d);
    expect_timeout = 1'b0;
    watch_mem("timeout", 17, 6'h11, 1'b0, 16'h0000);
    chk("timeout_err", err, 1);
    chk("timeout_wb_we", wb_we, 0);
`endif

    repeat (3) @(negedge clk);

    wait_cfg = 10;
    d = '0;
    d.op = 2'd2;
    d.addr = 6'h07;
    issue(d);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    last_data = '0;
    last_pc = '0;
    #1;
    chk("midreset_psel_penable", {psel, penable}, 0);
    chk("midreset_outs", {wb_valid, wb_we, wb_dst, wb_data, pc_load,
                          pwrite, paddr, pwdata, err}, 0);
    chk("midreset_PC_out", PC_out, 0);
    chk("midreset_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_wb_after_reset", wb_valid, 0);
    end
    wait_cfg = -1;

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(rand_instr());
    end

    for (int g = 0; g < 200 && exp_q.size() != 0; g++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
